// File: rtl/sprite_queue_pkg.sv
// Shared constants and the sprite command record used by the sprite queue and its storage.
package sprite_queue_pkg;

    localparam int SPRITE_QUEUE_DEPTH = 64;
    localparam int SPRITE_ID_W        = 8;
    localparam int SPRITE_X_W         = 16;
    localparam int SPRITE_Y_W         = 16;
    localparam int SPRITE_SCALE_W     = 8;
    localparam int SPRITE_ENTRY_W     = SPRITE_ID_W + SPRITE_X_W + SPRITE_Y_W + SPRITE_SCALE_W;

    typedef struct packed {
        logic [SPRITE_ID_W-1:0]    id;
        logic [SPRITE_X_W-1:0]     x;
        logic [SPRITE_Y_W-1:0]     y;
        logic [SPRITE_SCALE_W-1:0] scale;
    } sprite_cmd_t;

    // A zero scale would make the sprite vanish downstream, so it is promoted to unity.
    function automatic logic [SPRITE_SCALE_W-1:0] fix_scale(input logic [SPRITE_SCALE_W-1:0] s);
        return (s == '0) ? SPRITE_SCALE_W'(1) : s;
    endfunction

endpackage

// File: rtl/sprite_queue_mem.sv
// Simple dual-port DEPTH x 48 command RAM: one write port, one registered read port.
module sprite_queue_mem
    import sprite_queue_pkg::*;
#(
    parameter int DEPTH = SPRITE_QUEUE_DEPTH
) (
    input  logic                     clock,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  sprite_cmd_t              i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output sprite_cmd_t              o_rd_data
);

    sprite_cmd_t r_mem [DEPTH];
    sprite_cmd_t r_rd_data;

    // NOTE: the array and its read register carry no reset so the tools can map them onto block RAM.
    always_ff @(posedge clock) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en)
            r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sprite_queue.sv
// Show-ahead FIFO of sprite draw commands between the framebuffer controller and the renderers.
module sprite_queue
    import sprite_queue_pkg::*;
#(
    parameter int DEPTH = SPRITE_QUEUE_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        enqueue,
    input  logic [SPRITE_ID_W-1:0]      wr_sprite_id,
    input  logic [SPRITE_X_W-1:0]       wr_sprite_x,
    input  logic [SPRITE_Y_W-1:0]       wr_sprite_y,
    input  logic [SPRITE_SCALE_W-1:0]   wr_sprite_scale,
    output logic                        full,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    input  logic                        sprite_queue_dequeue,
    output logic                        sprite_queue_is_empty,
    output logic [SPRITE_ID_W-1:0]      sprite_queue_sprite_id,
    output logic [SPRITE_X_W-1:0]       sprite_queue_sprite_x,
    output logic [SPRITE_Y_W-1:0]       sprite_queue_sprite_y,
    output logic [SPRITE_SCALE_W-1:0]   sprite_queue_sprite_scale,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic          r_full, r_empty, r_overflow, r_underflow;
    logic          r_sel_byp;
    sprite_cmd_t   r_byp;

    sprite_cmd_t   w_wr_data, w_mem_q, w_head;
    logic          w_pop, w_push, w_load_byp, w_rd_en, w_mem_we;
    logic [CW-1:0] w_count_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_wr_data       = '0;
        w_wr_data.id    = wr_sprite_id;
        w_wr_data.x     = wr_sprite_x;
        w_wr_data.y     = wr_sprite_y;
        w_wr_data.scale = fix_scale(wr_sprite_scale);

        w_pop        = sprite_queue_dequeue && !r_empty;
        w_push       = enqueue && (!r_full || w_pop);
        w_count_next = r_count + CW'(w_push) - CW'(w_pop);

        // The new entry becomes the head directly when nothing older would sit in front of it.
        w_load_byp = w_push && (r_empty || (w_pop && r_count == CW'(1)));
        w_rd_en    = w_pop && (r_count > CW'(1)) && !flush && !reset;
        w_mem_we   = w_push && !flush && !reset;
    end

    sprite_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clock     (clock),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr + AW'(1)),
        .o_rd_data (w_mem_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_sel_byp   <= 1'b1;
            r_byp       <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_count  <= w_count_next;
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_full   <= (w_count_next == CW'(DEPTH));
            r_empty  <= (w_count_next == '0);
            if (enqueue && !w_push)
                r_overflow <= 1'b1;
            if (sprite_queue_dequeue && r_empty)
                r_underflow <= 1'b1;
            if (w_load_byp) begin
                r_sel_byp <= 1'b1;
                r_byp     <= w_wr_data;
            end else if (w_rd_en) begin
                r_sel_byp <= 1'b0;
            end
        end
    end

    // Both mux inputs and the select are registers, so no input reaches an output combinationally.
    assign w_head = r_sel_byp ? r_byp : w_mem_q;

    assign full                      = r_full;
    assign count                     = r_count;
    assign sprite_queue_is_empty     = r_empty;
    assign sprite_queue_sprite_id    = w_head.id;
    assign sprite_queue_sprite_x     = w_head.x;
    assign sprite_queue_sprite_y     = w_head.y;
    assign sprite_queue_sprite_scale = w_head.scale;
    assign overflow                  = r_overflow;
    assign underflow                 = r_underflow;

endmodule

// File: tb/tb_sprite_queue.sv
// Randomized scoreboard bench for sprite_queue against a queue-based reference model.
module tb_sprite_queue;
    import sprite_queue_pkg::*;

    localparam int DEPTH = SPRITE_QUEUE_DEPTH;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clock = 1'b0;
    logic          reset, flush, enqueue, dequeue;
    logic [7:0]    wr_id, wr_scale;
    logic [15:0]   wr_x, wr_y;
    logic          full, is_empty, overflow, underflow;
    logic [CW-1:0] count;
    logic [7:0]    hd_id, hd_scale;
    logic [15:0]   hd_x, hd_y;

    always #5 clock = ~clock;

    sprite_queue #(.DEPTH(DEPTH)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .flush                     (flush),
        .enqueue                   (enqueue),
        .wr_sprite_id              (wr_id),
        .wr_sprite_x               (wr_x),
        .wr_sprite_y               (wr_y),
        .wr_sprite_scale           (wr_scale),
        .full                      (full),
        .count                     (count),
        .sprite_queue_dequeue      (dequeue),
        .sprite_queue_is_empty     (is_empty),
        .sprite_queue_sprite_id    (hd_id),
        .sprite_queue_sprite_x     (hd_x),
        .sprite_queue_sprite_y     (hd_y),
        .sprite_queue_sprite_scale (hd_scale),
        .overflow                  (overflow),
        .underflow                 (underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of expected commands plus sticky flags.
    sprite_cmd_t sb[$];
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge clock) begin : model
        sprite_cmd_t e;
        if (reset) begin
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (dequeue) begin
                if (sb.size() > 0) void'(sb.pop_front());
                else m_udf = 1'b1;
            end
            if (enqueue) begin
                if (sb.size() < DEPTH) begin
                    e.id    = wr_id;
                    e.x     = wr_x;
                    e.y     = wr_y;
                    e.scale = (wr_scale == 8'd0) ? 8'd1 : wr_scale;
                    sb.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor: whenever the DUT presents a head entry it must equal the oldest expected command.
    always @(negedge clock) begin
        if (mon_en) begin
            check("count", 64'(count), 64'(sb.size()));
            check("is_empty", 64'(is_empty), 64'(sb.size() == 0));
            check("full", 64'(full), 64'(sb.size() == DEPTH));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("underflow", 64'(underflow), 64'(m_udf));
            if (!is_empty && sb.size() > 0)
                check("head", 64'({hd_id, hd_x, hd_y, hd_scale}), 64'(sb[0]));
        end
    end

    task automatic drive(input bit rst, input bit fl, input bit enq, input bit deq,
                         input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] sc);
        @(negedge clock);
        reset   = rst;
        flush   = fl;
        enqueue = enq;
        dequeue = deq;
        wr_id   = id;
        wr_x    = x;
        wr_y    = y;
        wr_scale = sc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 8'd0);
    endtask

    task automatic push(input logic [7:0] id);
        drive(1'b0, 1'b0, 1'b1, 1'b0, id, 16'($urandom), 16'($urandom), 8'($urandom));
    endtask

    task automatic pop();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0, 16'd0, 8'd0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 8'd0);
        idle();
        check("reset_head", 64'({hd_id, hd_x, hd_y, hd_scale}), 64'd0);
        check("reset_empty", 64'(is_empty), 64'd1);
        check("reset_count", 64'(count), 64'd0);
        mon_en = 1'b1;

        // Single enqueue into an empty queue.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 16'd100, 16'd50, 8'd2);
        idle();
        check("first_head", 64'({hd_id, hd_x, hd_y, hd_scale}), 64'({8'd3, 16'd100, 16'd50, 8'd2}));
        check("first_count", 64'(count), 64'd1);

        // Fill to DEPTH, overflow once, then drain in order.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 8'd0);
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        push(8'd200);
        idle();
        check("full_after_fill", 64'(full), 64'd1);
        check("overflow_set", 64'(overflow), 64'd1);
        for (int i = 0; i < DEPTH; i++) pop();
        idle();

        // Simultaneous enqueue and dequeue on a one-entry queue.
        push(8'd10);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd11, 16'd7, 16'd8, 8'd9);
        idle();
        check("swap_head", 64'(hd_id), 64'd11);
        pop();
        idle();

        // Dequeue while empty, then normal operation continues.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 8'd0);
        pop();
        idle();
        check("underflow_set", 64'(underflow), 64'd1);
        push(8'd42);
        idle();

        // Flush outranks concurrent enqueue and dequeue.
        for (int i = 0; i < 10; i++) push(8'(i + 1));
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd99, 16'd1, 16'd1, 8'd1);
        idle();
        check("flush_count", 64'(count), 64'd0);

        // Scale zero is stored as one.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 16'd6, 16'd7, 8'd0);
        idle();
        check("scale_fix", 64'(hd_scale), 64'd1);

        // Randomized traffic with alternating fill/drain bias.
        for (int i = 0; i < 4000; i++) begin
            bit fill = ((i / 300) % 2) == 0;
            bit enq  = $urandom_range(0, 99) < (fill ? 70 : 35);
            bit deq  = $urandom_range(0, 99) < (fill ? 35 : 70);
            bit fl   = $urandom_range(0, 199) == 0;
            bit rst  = $urandom_range(0, 799) == 0;
            logic [7:0] sc = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            drive(rst, fl, enq, deq, 8'($urandom), 16'($urandom), 16'($urandom), sc);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
